// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - miss-handling block fill controller for the 2-way data cache
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [15:0]       memory_data,
    output logic              fsm_busy,
    output logic              mem_read,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [15:0]       fill_data,
    output logic              write_tag_array
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);
    localparam logic [3:0] NUM_WORDS = 4'(BLOCK_WORDS);

    state_t              state;
    logic [ADDR_W-5:0]   base;
    logic [3:0]          req_cnt;
    logic [3:0]          rcv_cnt;

    // Word offset within the block is rebuilt from the counters, so the low
    // nibble of the miss address is intentionally dropped.
    logic unused_miss_low;
    assign unused_miss_low = &{1'b0, miss_address[3:0]};

    logic req_open;
    logic rcv_take;
    assign req_open = (req_cnt < NUM_WORDS);
    assign rcv_take = memory_data_valid && (rcv_cnt < NUM_WORDS);

    // State, block base and request/receive counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            base    <= '0;
            req_cnt <= '0;
            rcv_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base    <= miss_address[ADDR_W-1:4];
                        req_cnt <= '0;
                        rcv_cnt <= '0;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (req_open) begin
                        req_cnt <= req_cnt + 4'd1;
                    end
                    if (rcv_take) begin
                        rcv_cnt <= rcv_cnt + 4'd1;
                        if (rcv_cnt == LAST_WORD) begin
                            state <= TAG;
                        end
                    end
                end
                TAG: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; busy in IDLE follows the miss
    // so the pipeline stalls in the same cycle the miss is reported.
    always_comb begin
        fsm_busy         = 1'b0;
        mem_read         = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_addr        = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;
        case (state)
            IDLE: begin
                fsm_busy = miss_detected;
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (req_open) begin
                    mem_read       = 1'b1;
                    memory_address = {base, req_cnt[2:0], 1'b0};
                end
                if (rcv_take) begin
                    write_data_array = 1'b1;
                    fill_addr        = {base, rcv_cnt[2:0], 1'b0};
                    fill_data        = memory_data;
                end
            end
            TAG: begin
                fsm_busy        = 1'b1;
                write_tag_array = 1'b1;
                fill_addr       = {base, 4'b0000};
            end
            default: begin
                fsm_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed self-checking bench for cache_fill_fsm
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'h0;
    logic        fsm_busy;
    logic        mem_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_addr;
    logic [15:0] fill_data;
    logic        write_tag_array;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read          (mem_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_addr         (fill_addr),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int lat_mode = 0;
    int lat_fixed = 4;
    int last_ready = -100;
    int nreq = 0;
    bit spur = 1'b0;

    logic [15:0] q_a[$];
    int          q_r[$];
    int          req_t[$];
    logic [15:0] req_a[$];
    int          wr_t[$];
    logic [15:0] wr_a[$];
    logic [15:0] wr_d[$];
    int          tag_t[$];
    logic [15:0] tag_a[$];
    int          busy_t[$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        req_t.delete(); req_a.delete();
        wr_t.delete(); wr_a.delete(); wr_d.delete();
        tag_t.delete(); tag_a.delete(); busy_t.delete();
        t0 = cyc;
        nreq = 0;
        last_ready = -100;
    endtask

    // One clock cycle: drive inputs mid-cycle, let memory respond in order,
    // then sample and log the combinational outputs for this cycle.
    task automatic tick(input logic r, input logic m, input logic [15:0] a);
        int lat;
        int rdy;
        int gap;
        @(negedge clk);
        rst = r;
        miss_detected = m;
        miss_address = a;
        if (q_a.size() > 0 && q_r[0] <= cyc) begin
            memory_data_valid = 1'b1;
            memory_data = mem_word(q_a[0]);
            void'(q_a.pop_front());
            void'(q_r.pop_front());
        end else begin
            memory_data_valid = spur;
            memory_data = spur ? 16'hDEAD : 16'h0000;
        end
        #1;
        if (mem_read) begin
            lat = (lat_mode == 0) ? lat_fixed : ((nreq % 2 == 0) ? 1 : 6);
            gap = (lat_mode == 1 && (nreq == 2 || nreq == 5)) ? 2 : 1;
            rdy = cyc + lat;
            if (rdy < last_ready + gap) rdy = last_ready + gap;
            q_a.push_back(memory_address);
            q_r.push_back(rdy);
            last_ready = rdy;
            nreq++;
            req_t.push_back(cyc - t0);
            req_a.push_back(memory_address);
        end
        if (write_data_array) begin
            wr_t.push_back(cyc - t0);
            wr_a.push_back(fill_addr);
            wr_d.push_back(fill_data);
        end
        if (write_tag_array) begin
            tag_t.push_back(cyc - t0);
            tag_a.push_back(fill_addr);
        end
        if (fsm_busy) busy_t.push_back(cyc - t0);
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fsm_busy || q_a.size() != 0) && n < 60) begin
            tick(1'b1, 1'b0, 16'h0);
            n++;
        end
        chk("drain_bound", 32'(n < 60), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, {9'd0, fsm_busy, mem_read, memory_address, write_data_array,
                  write_tag_array, 3'd0}, 32'd0);
        chk({tag, "_fill"}, {fill_addr, fill_data}, 32'd0);
    endtask

    initial begin
        int irr_t[8];
        irr_t = '{2, 8, 10, 11, 12, 14, 15, 16};

        // Reset state
        tick(1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 16'h0);
        chk_outputs_zero("reset_outputs");

        // Basic fill at L=4 followed by a back-to-back miss at 0x4000
        clear_logs();
        lat_mode = 0;
        lat_fixed = 4;
        tick(1'b1, 1'b1, 16'h1236);
        for (int i = 1; i <= 13; i++) tick(1'b1, 1'b0, 16'h0);
        tick(1'b1, 1'b1, 16'h4000);
        drain();
        chk("basic_req_count", 32'(req_t.size()), 32'd16);
        chk("basic_wr_count", 32'(wr_t.size()), 32'd16);
        for (int k = 0; k < 8; k++) begin
            chk("basic_req_cycle", 32'(req_t[k]), 32'(k + 1));
            chk("basic_req_addr", {16'h0, req_a[k]}, 32'h1230 + 32'(2 * k));
            chk("basic_wr_cycle", 32'(wr_t[k]), 32'(k + 5));
            chk("basic_wr_addr", {16'h0, wr_a[k]}, 32'h1230 + 32'(2 * k));
            chk("basic_wr_data", {16'h0, wr_d[k]}, {16'h0, mem_word(16'h1230 + 16'(2 * k))});
        end
        chk("b2b_first_req_cycle", 32'(req_t[8]), 32'd15);
        chk("b2b_first_req_addr", {16'h0, req_a[8]}, 32'h4000);
        chk("b2b_last_req_addr", {16'h0, req_a[15]}, 32'h400E);
        chk("b2b_first_wr_cycle", 32'(wr_t[8]), 32'd19);
        chk("b2b_last_wr_addr", {16'h0, wr_a[15]}, 32'h400E);
        chk("basic_tag_count", 32'(tag_t.size()), 32'd2);
        chk("basic_tag_cycle", 32'(tag_t[0]), 32'd13);
        chk("basic_tag_addr", {16'h0, tag_a[0]}, 32'h1230);
        chk("b2b_tag_cycle", 32'(tag_t[1]), 32'd27);
        chk("b2b_tag_addr", {16'h0, tag_a[1]}, 32'h4000);
        chk("b2b_busy_count", 32'(busy_t.size()), 32'd28);
        chk("b2b_busy_first", 32'(busy_t[0]), 32'd0);
        chk("b2b_busy_last", 32'(busy_t[27]), 32'd27);

        // Top-of-memory block, L=2
        clear_logs();
        lat_fixed = 2;
        tick(1'b1, 1'b1, 16'hFFFF);
        drain();
        chk("top_req_count", 32'(req_t.size()), 32'd8);
        chk("top_first_req", {16'h0, req_a[0]}, 32'hFFF0);
        chk("top_last_req", {16'h0, req_a[7]}, 32'hFFFE);
        chk("top_wr_count", 32'(wr_t.size()), 32'd8);
        chk("top_last_wr", {16'h0, wr_a[7]}, 32'hFFFE);
        chk("top_tag_cycle", 32'(tag_t[0]), 32'd11);
        chk("top_tag_addr", {16'h0, tag_a[0]}, 32'hFFF0);

        // Irregular latency with injected idle cycles
        clear_logs();
        lat_mode = 1;
        tick(1'b1, 1'b1, 16'hA5A0);
        drain();
        chk("irr_wr_count", 32'(wr_t.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("irr_wr_cycle", 32'(wr_t[k]), 32'(irr_t[k]));
            chk("irr_wr_addr", {16'h0, wr_a[k]}, 32'hA5A0 + 32'(2 * k));
            chk("irr_wr_data", {16'h0, wr_d[k]}, {16'h0, mem_word(16'hA5A0 + 16'(2 * k))});
        end
        chk("irr_tag_count", 32'(tag_t.size()), 32'd1);
        chk("irr_tag_cycle", 32'(tag_t[0]), 32'd17);

        // Reset in the cycle of the third write
        clear_logs();
        lat_mode = 0;
        lat_fixed = 2;
        tick(1'b1, 1'b1, 16'h3330);
        for (int i = 1; i <= 4; i++) tick(1'b1, 1'b0, 16'h0);
        tick(1'b0, 1'b0, 16'h0);
        tick(1'b1, 1'b0, 16'h0);
        chk_outputs_zero("rst_mid_outputs");
        drain();
        chk("rst_mid_wr_count", 32'(wr_t.size()), 32'd3);
        chk("rst_mid_third_addr", {16'h0, wr_a[2]}, 32'h3334);
        chk("rst_mid_tag_count", 32'(tag_t.size()), 32'd0);
        clear_logs();
        tick(1'b1, 1'b1, 16'h3338);
        drain();
        chk("rst_refill_wr_count", 32'(wr_t.size()), 32'd8);
        chk("rst_refill_first_addr", {16'h0, wr_a[0]}, 32'h3330);
        chk("rst_refill_first_data", {16'h0, wr_d[0]}, {16'h0, mem_word(16'h3330)});
        chk("rst_refill_last_addr", {16'h0, wr_a[7]}, 32'h333E);
        chk("rst_refill_tag_count", 32'(tag_t.size()), 32'd1);

        // Spurious valids in IDLE, then miss toggled with a new address mid-fill
        clear_logs();
        lat_fixed = 3;
        spur = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0);
        spur = 1'b0;
        chk("spur_idle_writes", 32'(wr_t.size()), 32'd0);
        chk("spur_idle_busy", 32'(busy_t.size()), 32'd0);
        clear_logs();
        tick(1'b1, 1'b1, 16'h2468);
        for (int i = 1; i <= 12; i++) tick(1'b1, 1'(i % 2), 16'h9990);
        drain();
        chk("spur_req_count", 32'(req_t.size()), 32'd8);
        chk("spur_wr_count", 32'(wr_t.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("spur_req_addr", {16'h0, req_a[k]}, 32'h2460 + 32'(2 * k));
            chk("spur_wr_addr", {16'h0, wr_a[k]}, 32'h2460 + 32'(2 * k));
        end
        chk("spur_tag_count", 32'(tag_t.size()), 32'd1);
        chk("spur_tag_cycle", 32'(tag_t[0]), 32'd12);
        chk("spur_tag_addr", {16'h0, tag_a[0]}, 32'h2460);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller for the 2-way set-associative data cache. It accepts a miss from the cache's tag-compare logic and fetches the 16-byte block (8 × 16-bit words) from a pipelined, latency-insensitive main memory. It streams each returned word into the cache data array and finally writes the tag/valid/LRU metadata. It sits between the cache and the memory model, and its `fsm_busy` stalls the pipeline for the duration of the fill.

## Interface
- `BLOCK_WORDS`, 8, words per cache block; fixed at 8 for 16-byte blocks of 16-bit words.
- `ADDR_W`, 16, byte-address width.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `miss_detected`  in  1  cache reports a miss for `miss_address` this cycle.
- `miss_address`  in  16  byte address of the missing access.
- `memory_data_valid`  in  1  `memory_data` carries the next returned word.
- `memory_data`  in  16  word returned by memory, in request order.
- `fsm_busy`  out  1  fill in progress; pipeline must stall.
- `mem_read`  out  1  memory read request strobe.
- `memory_address`  out  16  byte address of the current request.
- `write_data_array`  out  1  write `fill_data` into the data array at `fill_addr`.
- `fill_addr`  out  16  byte address of the word being written; the cache derives set and word select from it.
- `fill_data`  out  16  word to write; equals `memory_data`.
- `write_tag_array`  out  1  one-cycle strobe to install the tag, set valid and update LRU for the victim way.

## Operation
- States: IDLE, FILL, TAG. Reset state is IDLE.
- Registers:
  - `base`: 12-bit block address.
  - `req_cnt`: 4-bit count of requests issued.
  - `rcv_cnt`: 4-bit count of words received.
- IDLE:
  - all outputs 0 except `fsm_busy`, which is combinationally 1 if `miss_detected`=1.
  - On `miss_detected`=1: latch `base`=`miss_address[15:4]`, clear both counters, go to FILL.
  - `memory_data_valid` is ignored in IDLE.
- FILL:
  - `fsm_busy`=1.
  - While `req_cnt`<8: `mem_read`=1, `memory_address`={`base`, `req_cnt[2:0]`, 1'b0}, and `req_cnt` increments. Otherwise `mem_read`=0 and `memory_address`=0.
  - When `memory_data_valid`=1 and `rcv_cnt`<8: `write_data_array`=1, `fill_addr`={`base`, `rcv_cnt[2:0]`, 1'b0}, `fill_data`=`memory_data`, and `rcv_cnt` increments.
  - Requests and receipts may overlap in the same cycle.
  - When the eighth word is accepted (`rcv_cnt`==7 with valid), go to TAG.
- TAG:
  - `fsm_busy`=1 and `write_tag_array`=1 for exactly one cycle, with `fill_addr`={`base`, 4'b0}.
  - Then go to IDLE.
- Address arithmetic is concatenation only, so no carry crosses into `base`. A block at 0xFFF0 requests 0xFFF0..0xFFFE and never wraps to 0x0000.
- `miss_detected` is ignored outside IDLE; the cache holds its miss while `fsm_busy`=1.
- Extra `memory_data_valid` pulses in FILL after `rcv_cnt`==8 cannot occur by construction; any valid in TAG or IDLE is ignored.
- When deasserted, outputs `memory_address`, `fill_addr` and `fill_data` are driven 0.

## Timing
- Reset: every output is 0 and counters are 0 on the cycle after `rst`=0 is sampled. This holds even mid-FILL or mid-TAG, and no `write_tag_array` is issued for an aborted fill.
- Miss in cycle 0: first request in cycle 1; requests in cycles 1–8, one per cycle.
- With latency L (request at t, valid at t+L), words are written in cycles 1+L … 8+L, TAG is cycle 9+L, and `fsm_busy` falls in cycle 10+L. For L=4 that is 14 busy cycles, counting the combinational busy in cycle 0.
- A new `miss_detected` in the cycle after TAG starts a new fill immediately.
- Gaps in `memory_data_valid` stall only the receive side; no word is ever dropped or duplicated.

## Test plan
- Basic fill, L=4:
  - Stimulus: miss at 0x1236 in cycle 0.
  - Required: requests to 0x1230, 0x1232, …, 0x123E in cycles 1–8; data writes at those `fill_addr` in cycles 5–12; `write_tag_array` in cycle 13 only; `fsm_busy` 1 for cycles 0–13.
- Top-of-memory block:
  - Stimulus: miss at 0xFFFF.
  - Required: the last request and last write address are 0xFFFE; `base` stays 0xFFF.
- Irregular memory: latency 1 for even words, 6 for odd words, with 2 idle cycles injected.
  - Required: exactly 8 writes in order with `fill_data` matching the memory model; TAG occurs once, one cycle after the eighth write.
- Reset mid-fill:
  - Stimulus: `rst`=0 after the third write.
  - Required: outputs all 0 next cycle; later valids produce no writes; no `write_tag_array`; a fresh miss afterwards fills correctly from word 0.
- Spurious inputs:
  - Stimulus: `memory_data_valid` pulses while IDLE, and `miss_detected` toggled with a new address during FILL.
  - Required: no writes while IDLE; fill addresses stay on the original block.
- Back-to-back misses:
  - Stimulus: a second miss at 0x4000 asserted in the cycle after TAG.
  - Required: first request 0x4000 in the following cycle; `fsm_busy` stays high continuously.
